vga_timing_gen: RTL and testbench

Parametrised VGA/raster timing generator: the next-generation replacement for the fixed 640x480 sync block. It derives a pixel-rate enable from the system clock and runs horizontal and vertical position counters. It decodes sync and blanking with configurable polarity, and provides line and frame strobes plus a frame counter. All raster outputs pass through a configurable delay line so they can be aligned with a downstream object/pixel pipeline.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, h/v position counters,
// sync/blank decode and a configurable-depth alignment delay line.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CLK_DIV   = 2,
    parameter int   DELAY     = 1,
    parameter int   CNT_W     = 10,
    parameter int   FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pixel_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int B_W     = 2 * CNT_W + 3;

    localparam logic [CNT_W-1:0]   H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]   V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]   H_ACT     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0]   V_ACT     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0]   HS_FIRST  = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0]   HS_LAST   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0]   VS_FIRST  = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0]   VS_LAST   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
    localparam logic [3:0]         DIV_LAST  = 4'(CLK_DIV - 1);

    // Delay stages power up blanked with both syncs inactive, not as the decode of h=v=0.
    localparam logic [B_W-1:0] RST_BUNDLE = {{(2 * CNT_W){1'b0}}, 1'b0, ~HSYNC_POL, ~VSYNC_POL};

    logic [3:0]         div_cnt_r;
    logic [CNT_W-1:0]   h_r;
    logic [CNT_W-1:0]   v_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               tick_s;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               video_on_s;
    logic               hsync_s;
    logic               vsync_s;
    logic [B_W-1:0]     bundle_s;
    logic [B_W-1:0]     out_bundle_s;

    // Strobe generation; strobes are held low while reset is asserted.
    always_comb begin
        tick_s   = 1'b0;
        h_wrap_s = 1'b0;
        v_wrap_s = 1'b0;
        tick_s   = en && !reset && (div_cnt_r == DIV_LAST);
        h_wrap_s = tick_s && (h_r == H_LAST);
        v_wrap_s = h_wrap_s && (v_r == V_LAST);
    end

    // Pixel-rate divider, frozen while en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= 4'd0;
        end else if (en) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= 4'd0;
            end else begin
                div_cnt_r <= div_cnt_r + 4'd1;
            end
        end
    end

    // Horizontal/vertical position and completed-frame counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_r         <= '0;
            v_r         <= '0;
            frame_cnt_r <= '0;
        end else if (tick_s) begin
            if (h_wrap_s) begin
                h_r <= '0;
                if (v_wrap_s) begin
                    v_r         <= '0;
                    frame_cnt_r <= frame_cnt_r + FRAME_ONE;
                end else begin
                    v_r <= v_r + CNT_ONE;
                end
            end else begin
                h_r <= h_r + CNT_ONE;
            end
        end
    end

    // Raster decode of the current position.
    always_comb begin
        video_on_s = 1'b0;
        hsync_s    = ~HSYNC_POL;
        vsync_s    = ~VSYNC_POL;
        video_on_s = (h_r < H_ACT) && (v_r < V_ACT);
        if ((h_r >= HS_FIRST) && (h_r <= HS_LAST)) begin
            hsync_s = HSYNC_POL;
        end else begin
            hsync_s = ~HSYNC_POL;
        end
        if ((v_r >= VS_FIRST) && (v_r <= VS_LAST)) begin
            vsync_s = VSYNC_POL;
        end else begin
            vsync_s = ~VSYNC_POL;
        end
    end

    assign bundle_s = {h_r, v_r, video_on_s, hsync_s, vsync_s};

    if (DELAY == 0) begin : g_direct
        assign out_bundle_s = bundle_s;
    end else begin : g_delay
        logic [B_W-1:0] pipe_r [DELAY];

        // Alignment shift register; runs every clk so frozen positions propagate through.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DELAY; i++) begin
                    pipe_r[i] <= RST_BUNDLE;
                end
            end else begin
                pipe_r[0] <= bundle_s;
                for (int i = 1; i < DELAY; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign out_bundle_s = pipe_r[DELAY-1];
    end

    assign {x, y, video_on, hsync, vsync} = out_bundle_s;
    assign pixel_tick  = tick_s;
    assign line_start  = h_wrap_s;
    assign frame_start = v_wrap_s;
    assign frame_count = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: three instances on a 12x7 raster with
// different divider, delay and polarity settings, checked at hand-computed cycles.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    // A: CLK_DIV=2, DELAY=2, active-low syncs, FRAME_W=2
    logic       a_tick, a_ls, a_fs, a_von, a_hs, a_vs;
    logic [3:0] a_x, a_y;
    logic [1:0] a_fc;
    // B: CLK_DIV=1, DELAY=0, active-high syncs
    logic       b_tick, b_ls, b_fs, b_von, b_hs, b_vs;
    logic [3:0] b_x, b_y;
    logic [7:0] b_fc;
    // C: CLK_DIV=1, DELAY=4, active-low syncs
    logic       c_tick, c_ls, c_fs, c_von, c_hs, c_vs;
    logic [3:0] c_x, c_y;
    logic [7:0] c_fc;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .DELAY(2),
        .CNT_W(4), .FRAME_W(2)
    ) u_a (
        .clk(clk), .reset(reset), .en(en),
        .pixel_tick(a_tick), .line_start(a_ls), .frame_start(a_fs),
        .x(a_x), .y(a_y), .video_on(a_von), .hsync(a_hs), .vsync(a_vs),
        .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .DELAY(0),
        .CNT_W(4), .FRAME_W(8)
    ) u_b (
        .clk(clk), .reset(reset), .en(en),
        .pixel_tick(b_tick), .line_start(b_ls), .frame_start(b_fs),
        .x(b_x), .y(b_y), .video_on(b_von), .hsync(b_hs), .vsync(b_vs),
        .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .DELAY(4),
        .CNT_W(4), .FRAME_W(8)
    ) u_c (
        .clk(clk), .reset(reset), .en(en),
        .pixel_tick(c_tick), .line_start(c_ls), .frame_start(c_fs),
        .x(c_x), .y(c_y), .video_on(c_von), .hsync(c_hs), .vsync(c_vs),
        .frame_count(c_fc)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int a_tk_cnt = 0;
    int a_ls_cnt = 0;
    int a_fs_cnt = 0;
    int b_fs_cnt = 0;
    int strobe_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk: sample 1 time unit after the rising edge and tally strobes.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (a_tick) a_tk_cnt++;
        if (a_ls) a_ls_cnt++;
        if (a_fs) a_fs_cnt++;
        if (b_fs) b_fs_cnt++;
        if (a_tick || a_ls || a_fs || b_tick || b_ls || b_fs || c_tick || c_ls || c_fs) strobe_cnt++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_counts();
        cyc = 0; a_tk_cnt = 0; a_ls_cnt = 0; a_fs_cnt = 0; b_fs_cnt = 0; strobe_cnt = 0;
    endtask

    initial begin
        // Held in reset
        step(); step();
        chk("rst_a_tick", a_tick, 0);
        chk("rst_a_ls", a_ls, 0);
        chk("rst_a_fs", a_fs, 0);
        chk("rst_a_x", a_x, 0);
        chk("rst_a_y", a_y, 0);
        chk("rst_a_von", a_von, 0);
        chk("rst_a_hs", a_hs, 1);
        chk("rst_a_vs", a_vs, 1);
        chk("rst_a_fc", a_fc, 0);
        chk("rst_b_von", b_von, 1);
        chk("rst_b_hs", b_hs, 0);
        chk("rst_b_vs", b_vs, 0);
        chk("rst_c_von", c_von, 0);

        // Release with en=1; this is cycle 0
        reset = 1'b0;
        en    = 1'b1;
        clear_counts();
        #1;
        chk("c0_a_tick", a_tick, 0);
        chk("c0_b_tick", b_tick, 1);
        chk("c0_a_von", a_von, 0);
        chk("c0_b_x", b_x, 0);
        chk("c0_b_von", b_von, 1);
        run_to(1);
        chk("c1_a_tick", a_tick, 1);
        chk("c1_a_von", a_von, 0);
        run_to(2);
        chk("c2_a_tick", a_tick, 0);
        chk("c2_a_von", a_von, 1);
        chk("c2_a_x", a_x, 0);
        run_to(3);
        chk("c3_c_von", c_von, 0);
        run_to(4);
        chk("c4_a_x", a_x, 1);
        chk("c4_c_von", c_von, 1);
        run_to(7);
        chk("c7_c_x", c_x, 3);
        run_to(8);
        chk("c8_b_hs", b_hs, 0);
        chk("c8_b_von", b_von, 0);
        run_to(9);
        chk("c9_b_hs", b_hs, 1);
        run_to(10);
        chk("c10_b_hs", b_hs, 1);
        run_to(11);
        chk("c11_b_hs", b_hs, 0);
        chk("c11_b_ls", b_ls, 1);
        run_to(12);
        chk("c12_c_hs", c_hs, 1);
        run_to(13);
        chk("c13_c_hs", c_hs, 0);
        run_to(17);
        chk("c17_a_von", a_von, 1);
        run_to(18);
        chk("c18_a_von", a_von, 0);
        run_to(19);
        chk("c19_a_hs", a_hs, 1);
        run_to(20);
        chk("c20_a_hs", a_hs, 0);
        run_to(21);
        chk("c21_a_tick", a_tick, 1);
        chk("c21_a_ls", a_ls, 0);
        run_to(22);
        chk("c22_a_tick", a_tick, 0);
        chk("c22_a_ls_cnt", a_ls_cnt, 0);
        run_to(23);
        chk("c23_a_hs", a_hs, 0);
        chk("c23_a_ls", a_ls, 1);
        chk("c23_a_ls_cnt", a_ls_cnt, 1);
        run_to(24);
        chk("c24_a_hs", a_hs, 1);
        run_to(50);
        chk("c50_a_y", a_y, 2);
        chk("c50_a_x", a_x, 0);
        run_to(83);
        chk("c83_b_fs", b_fs, 1);
        chk("c83_b_fc", b_fc, 0);
        run_to(84);
        chk("c84_b_fc", b_fc, 1);
        run_to(121);
        chk("c121_a_vs", a_vs, 1);
        run_to(122);
        chk("c122_a_vs", a_vs, 0);
        run_to(145);
        chk("c145_a_vs", a_vs, 0);
        run_to(146);
        chk("c146_a_vs", a_vs, 1);
        run_to(167);
        chk("c167_a_fs", a_fs, 1);
        chk("c167_a_fc", a_fc, 0);
        chk("c167_b_fs", b_fs, 1);
        run_to(168);
        chk("c168_a_fc", a_fc, 1);
        chk("c168_b_fc", b_fc, 2);
        chk("c168_a_tk_cnt", a_tk_cnt, 84);
        chk("c168_a_ls_cnt", a_ls_cnt, 7);
        chk("c168_a_fs_cnt", a_fs_cnt, 1);

        // en low for 37 clks, dropped on a pixel_tick cycle
        run_to(181);
        chk("c181_a_tick_pre", a_tick, 1);
        en = 1'b0;
        #1;
        chk("c181_a_tick_supp", a_tick, 0);
        chk("c181_b_tick_supp", b_tick, 0);
        strobe_cnt = 0;
        run_to(218);
        chk("hold_strobes", strobe_cnt, 0);
        chk("hold_a_x", a_x, 6);
        chk("hold_a_y", a_y, 0);
        chk("hold_a_fc", a_fc, 1);
        chk("hold_b_x", b_x, 1);
        chk("hold_b_y", b_y, 1);
        chk("hold_b_fc", b_fc, 2);
        chk("hold_c_x", c_x, 1);
        en = 1'b1;
        #1;
        chk("resume_a_tick", a_tick, 1);
        chk("resume_b_tick", b_tick, 1);
        run_to(219);
        chk("c219_a_x", a_x, 6);
        chk("c219_b_x", b_x, 2);
        run_to(221);
        chk("c221_a_x", a_x, 7);

        // Asynchronous reset mid-frame
        run_to(233);
        chk("c233_a_x", a_x, 1);
        chk("c233_a_y", a_y, 1);
        chk("c233_a_fc", a_fc, 1);
        chk("c233_b_x", b_x, 4);
        chk("c233_b_fc", b_fc, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_a_x", a_x, 0);
        chk("arst_a_y", a_y, 0);
        chk("arst_a_von", a_von, 0);
        chk("arst_a_hs", a_hs, 1);
        chk("arst_a_fc", a_fc, 0);
        chk("arst_a_tick", a_tick, 0);
        chk("arst_b_x", b_x, 0);
        chk("arst_b_fc", b_fc, 0);
        chk("arst_b_von", b_von, 1);
        chk("arst_c_hs", c_hs, 1);

        // Restart from h=v=0 and run four A frames to wrap the 2-bit frame counter
        reset = 1'b0;
        clear_counts();
        #1;
        chk("r0_a_tick", a_tick, 0);
        chk("r0_b_x", b_x, 0);
        run_to(4);
        chk("r4_a_x", a_x, 1);
        run_to(5);
        chk("r5_b_x", b_x, 5);
        run_to(671);
        chk("r671_a_fs", a_fs, 1);
        chk("r671_a_fc", a_fc, 3);
        run_to(672);
        chk("r672_a_fc", a_fc, 0);
        chk("r672_a_x", a_x, 11);
        chk("r672_a_y", a_y, 6);
        chk("r672_b_fc", b_fc, 8);
        chk("r672_a_ls_cnt", a_ls_cnt, 28);
        chk("r672_a_fs_cnt", a_fs_cnt, 4);
        chk("r672_b_fs_cnt", b_fs_cnt, 8);
        run_to(674);
        chk("r674_a_x", a_x, 0);
        chk("r674_a_y", a_y, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
